// File: rtl/booth_pkg.sv
// Shared FSM state codes and Booth recoding constants for the radix-2 sequential multiplier.
package booth_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    // Booth decode of {Q[0], Q_1}
    localparam logic [1:0] BOOTH_NOP_00 = 2'b00;
    localparam logic [1:0] BOOTH_ADD    = 2'b01;
    localparam logic [1:0] BOOTH_SUB    = 2'b10;
    localparam logic [1:0] BOOTH_NOP_11 = 2'b11;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic shift of {A,Q,Q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned E = 5
) (
    input  logic [E-1:0] a,
    input  logic [E-1:0] q,
    input  logic         q_1,
    input  logic [E-1:0] m,
    output logic [E-1:0] a_next,
    output logic [E-1:0] q_next,
    output logic         q_1_next
);

    logic [E-1:0] sum_c;

    always_comb begin
        sum_c = a;
        case ({q[0], q_1})
            BOOTH_ADD:                  sum_c = a + m;
            BOOTH_SUB:                  sum_c = a - m;
            BOOTH_NOP_00, BOOTH_NOP_11: sum_c = a;
            default:                    sum_c = a;
        endcase
    end

    // A's MSB is replicated; the bit shifted out of A enters Q
    assign a_next   = {sum_c[E-1], sum_c[E-1:1]};
    assign q_next   = {sum_c[0], q[E-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: start/busy/done handshake around an A/Q/Q_1 shift datapath.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned E  = WIDTH + 1;
    localparam int unsigned CW = $clog2(E + 1);
    localparam int unsigned PW = 2 * WIDTH;

    logic [STATE_W-1:0] state, state_n;
    logic [E-1:0]       a, a_n, q, q_n, m, m_n;
    logic               q_1, q_1_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               busy_n, done_n;
    logic [PW-1:0]      product_n;

    logic [E-1:0]       a_step_c, q_step_c;
    logic               q_1_step_c;
    logic [E-1:0]       m_ext_c, q_ext_c;

    // One extra bit lets unsigned operands ride through the signed Booth datapath
    assign m_ext_c = {is_signed & multiplicand[WIDTH-1], multiplicand};
    assign q_ext_c = {is_signed & multiplier[WIDTH-1], multiplier};

    booth_step #(.E(E)) u_step (
        .a        (a),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .a_next   (a_step_c),
        .q_next   (q_step_c),
        .q_1_next (q_1_step_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state   <= state_n;
            a       <= a_n;
            q       <= q_n;
            q_1     <= q_1_n;
            m       <= m_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            product <= product_n;
        end
    end

    always_comb begin
        state_n   = state;
        a_n       = a;
        q_n       = q;
        q_1_n     = q_1;
        m_n       = m;
        cnt_n     = cnt;
        done_n    = 1'b0;
        product_n = product;

        case (state)
            ST_IDLE, ST_DONE: begin
                state_n = ST_IDLE;
                if (start) begin
                    state_n = ST_RUN;
                    a_n     = '0;
                    q_n     = q_ext_c;
                    q_1_n   = 1'b0;
                    m_n     = m_ext_c;
                    cnt_n   = CW'(E);
                end
            end
            ST_RUN: begin
                a_n   = a_step_c;
                q_n   = q_step_c;
                q_1_n = q_1_step_c;
                cnt_n = cnt - CW'(1);
                // Final step: product is the low 2*WIDTH bits of the post-shift {A,Q}
                if (cnt == CW'(1)) begin
                    state_n   = ST_DONE;
                    done_n    = 1'b1;
                    product_n = {a_step_c[WIDTH-2:0], q_step_c};
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n == ST_RUN);
    end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Parametrised sequential radix-2 Booth multiplier that generalises the 4-bit A/Q load-and-shift register pair into a complete datapath with control.
- Contains the A/Q/Q-1 register chain, the multiplicand register M, a step counter and a start/busy/done handshake.
- Supports signed and unsigned operands at any WIDTH.
- Sits between the operand source and the result consumer in the Booth multiplier datapath, and replaces the hand-wired regA/regQ chain.

Parameters:
- WIDTH, 4, operand width in bits (≥2); the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- multiplicand  input  WIDTH  operand M; sampled with start
- multiplier  input  WIDTH  operand Q; sampled with start
- busy  output  1  high while the state is RUN
- done  output  1  one-cycle pulse; product valid and new
- product  output  2*WIDTH  registered result, held until the next done

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0; done=0; product=0.
  - A, Q, Q_1, M and count are all cleared.
- Internal widths:
  - E = WIDTH+1.
  - Operands are extended to E bits: sign-extended if is_signed=1, zero-extended otherwise.
  - A, Q and M are E bits wide; Q_1 is 1 bit; count is clog2(E+1) bits.
- Load (start=1 in IDLE or DONE, at edge E0):
  - A=0, Q=ext(multiplier), Q_1=0, M=ext(multiplicand), count=E.
  - state goes to RUN; busy=1 from the next cycle.
- RUN step (one per clock). Decode {Q[0],Q_1}:
  - 01: A=A+M.
  - 10: A=A-M.
  - 00 or 11: A unchanged.
  - Then arithmetic-shift {A,Q,Q_1} right by 1 (A's MSB is replicated), and decrement count.
- Arithmetic rules:
  - Add and subtract are modulo 2^E.
  - No overflow is possible, because ext(M) is never the most negative E-bit value.
- Finish:
  - The step that moves count from 1 to 0 occurs at edge E(WIDTH+1).
  - At that same edge: state=DONE, product = low 2*WIDTH bits of the post-shift {A,Q}, done=1, busy=0.
- Latency: done is high in the cycle starting WIDTH+1 clocks after the start edge.
- DONE lasts one cycle:
  - Goes to IDLE at the next edge.
  - If start=1 while in DONE, the new operands are loaded instead (back-to-back operation; done drops).
- start while busy: ignored. Operand changes during RUN have no effect.
- product: updates only on entry to DONE; otherwise it holds its value, including across IDLE and RUN.
- reset mid-RUN: immediate abort; all outputs return to their reset values; no done pulse is produced.
- Unsigned mode produces the full unsigned 2*WIDTH product (e.g. max*max); signed mode produces the full two's-complement product.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Booth decode constants (NOP=00 / ADD=01 / SUB=10 / NOP=11).
- Sub-module booth_step (combinational, parametrised E):
  - Inputs: A, Q, Q_1, M.
  - Outputs: next A, Q, Q_1 after the add/sub and arithmetic shift.
  - Reusable for an unrolled or radix-4 variant.
- Top level holds the FSM, counter, registers and product register.

Test Plan:
- WIDTH=4, signed, M=3, Q=-2 (4'hE), start 1 cycle -> busy for 5 cycles; done pulses at cycle 5 after the start edge; product=8'hFA.
- WIDTH=4, unsigned, M=15, Q=15 -> product=8'hE1. Same operands with signed=1 -> product=8'h01. Signed M=-8, Q=-8 -> product=8'h40.
- WIDTH=8, signed, M=-128 (8'h80), Q=127 -> product=16'hC080 after 9 step cycles. Unsigned 255*255 -> 16'hFE01.
- start re-asserted with new operands during RUN -> ignored; the first result is still correct. start held high through DONE -> next operation loads, done lasts one cycle, second product is correct.
- reset asserted asynchronously mid-RUN (count=2) -> busy, done and product go to 0 immediately without waiting for a clock edge; no done pulse; the next start yields a correct result.
- Randomised sweep: WIDTH=4 exhaustive over 256 operand pairs × both modes, compared against a reference multiply -> zero mismatches.
